assoc_cache: RTL
================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The block SHALL expose parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, CPU word width.
REQ-003 The block SHALL expose parameter WORDS_PER_BLOCK, default 4, power of 2 (>=2), words per line.
REQ-004 The block SHALL expose parameter SETS, default 8, power of 2 (>=2), sets per way; ways fixed at 2.
REQ-005 The ports SHALL be: clk  in  1  clock; all state updates on rising edge.
REQ-006 The ports SHALL be: rst_n  in  1  reset, synchronous, active-low.
REQ-007 The ports SHALL be: cpu_req  in  1  access request; cpu_we  in  1  1=write, 0=read.
REQ-008 The ports SHALL be: cpu_addr  in  ADDRESS_WIDTH  byte address; cpu_wdata  in  DATA_WIDTH  store data.
REQ-009 The ports SHALL be: cpu_rdata  out  DATA_WIDTH  load data; cpu_ready  out  1  access completes this cycle.
REQ-010 The ports SHALL be: mem_req  out  1; mem_we  out  1; mem_addr  out  ADDRESS_WIDTH  line-aligned.
REQ-011 The ports SHALL be: mem_wdata  out  DATA_WIDTH*WORDS_PER_BLOCK; mem_rdata  in  same width; mem_ack  in  1.

Function
REQ-012 Address split SHALL be: [1:0] byte, next log2(WORDS_PER_BLOCK) word offset, next log2(SETS) index, remainder tag.
REQ-013 Per line the block SHALL hold valid, dirty, tag, data; per set one LRU bit naming the least-recently-used way.
REQ-014 FSM states SHALL be IDLE, WRITEBACK, REFILL, DONE.
REQ-015 IDLE: cpu_req with tag match on a valid way SHALL assert cpu_ready combinationally in the same cycle; zero-wait hit.
REQ-016 Read hit: cpu_rdata = addressed word of hitting way; write hit: word updated and dirty set at the clock edge.
REQ-017 Any hit SHALL set LRU to the other way at the clock edge.
REQ-018 Miss victim SHALL be the invalid way (way 0 if both invalid), else the LRU way.
REQ-019 Miss with dirty valid victim: IDLE->WRITEBACK; mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
REQ-020 Miss with clean or invalid victim: IDLE->REFILL; mem_req=1, mem_we=0, mem_addr={cpu tag, index, 0}.
REQ-021 mem_req, mem_we, mem_addr, mem_wdata SHALL be held stable until mem_ack is sampled high; single-cycle ack ends the transfer.
REQ-022 WRITEBACK on ack: clear victim dirty, go to REFILL with mem_req continuously high (mem_we drops to 0, new address).
REQ-023 REFILL on ack: mem_rdata written into victim, valid=1, dirty=0, tag updated; mem_req=0 next cycle; go to DONE.
REQ-024 DONE: cpu_ready=1 for exactly one cycle, read served from installed line, write merged with dirty=1 (write-allocate), LRU -> other way; return to IDLE.
REQ-025 cpu_req, cpu_we, cpu_addr, cpu_wdata SHALL stay stable from assertion until cpu_ready; otherwise behaviour is undefined.
REQ-026 Clean-miss latency SHALL be (ack wait + 2) cycles from request to cpu_ready; dirty-miss adds the writeback ack wait + 1.
REQ-027 Outside IDLE-hit and DONE, cpu_ready SHALL be 0 and cpu_rdata 0; mem_req SHALL be 0 in IDLE and DONE.
REQ-028 mem_ack outside WRITEBACK/REFILL SHALL be ignored.

Reset
REQ-029 rst_n=0 at an edge SHALL clear all valid, dirty and LRU bits and force IDLE; data and tag arrays are not cleared.
REQ-030 During and after reset: cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-WRITEBACK/REFILL SHALL abandon the transfer; mem_req drops the cycle after the reset edge.

Configuration
REQ-032 Macro ASSOC_CACHE_STATS_EN defined SHALL add outputs hit_count and miss_count, each 32 bits, cleared by reset.
REQ-033 With ASSOC_CACHE_STATS_EN: hit_count +1 per IDLE hit completion, miss_count +1 per IDLE->WRITEBACK/REFILL transition, wrapping at 2^32.
REQ-034 Without ASSOC_CACHE_STATS_EN: the ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-035 After reset, read 0x0000_0104, mem_ack 3 cycles after mem_req, mem_rdata word1=0xDEAD_BEEF -> mem_addr=0x100, cpu_rdata=0xDEAD_BEEF in DONE, cpu_ready 5 cycles after request.
REQ-036 Repeat read 0x104 -> cpu_ready same cycle, cpu_rdata=0xDEAD_BEEF, mem_req stays 0.
REQ-037 Write 0xCAFE_0001 to 0x104, then reads to 0x904 and 0x1104 (same set 0) -> 0x904 fills way 1; 0x1104 evicts dirty way 0 with mem_we=1, mem_addr=0x100, mem_wdata word1=0xCAFE_0001, then refill mem_addr=0x1100.
REQ-038 Write miss to 0x208 with cpu_wdata=0x1234_5678 -> refill 0x200, DONE cpu_ready=1, subsequent read 0x208 hits returning 0x1234_5678.
REQ-039 rst_n=0 asserted while in REFILL with mem_ack never given -> mem_req=0 next cycle; read 0x104 afterwards misses.
REQ-040 With ASSOC_CACHE_STATS_EN, scenarios REQ-035 then REQ-036 -> miss_count=1, hit_count=1.

Source files
------------

// File: rtl/assoc_cache.sv
// Two-way set-associative write-back, write-allocate cache between a CPU port and a line-wide memory port.
// Latency: hit completes in the request cycle; a clean miss takes refill ack wait + 2 cycles, and a dirty miss adds writeback ack wait + 1.
// Backpressure: the CPU holds its request until cpu_ready, and the memory transfer is held stable until mem_ack is sampled high.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_req/we/addr/wdata CPU access request (held stable until cpu_ready)
//   cpu_rdata, cpu_ready  load data and completion strobe (combinational on hit)
//   mem_req/we/addr/wdata line transfer to memory (registered, line-aligned address)
//   mem_rdata, mem_ack    refill data and single-cycle transfer acknowledge
//   hit_count, miss_count present only when ASSOC_CACHE_STATS_EN is defined
//
// Optional feature macro: ASSOC_CACHE_STATS_EN adds 32-bit hit/miss counters.
module assoc_cache #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cpu_req,
    input  logic                                  cpu_we,
    input  logic [ADDRESS_WIDTH-1:0]              cpu_addr,
    input  logic [DATA_WIDTH-1:0]                 cpu_wdata,
    output logic [DATA_WIDTH-1:0]                 cpu_rdata,
    output logic                                  cpu_ready,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
    input  logic                                  mem_ack
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0]                           hit_count,
    output logic [31:0]                           miss_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(SETS);
    localparam int LSB_W  = OFF_W + 2;
    localparam int TAG_W  = ADDRESS_WIDTH - LSB_W - IDX_W;
    localparam int LINE_W = DATA_WIDTH * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        DONE      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage: status bits are reset, tag and data arrays are not.
    // ------------------------------------------------------------------
    logic [1:0][SETS-1:0] r_valid;
    logic [1:0][SETS-1:0] r_dirty;
    logic [SETS-1:0]      r_lru;      // names the least-recently-used way
    logic [TAG_W-1:0]     r_tag  [2][SETS];
    logic [LINE_W-1:0]    r_data [2][SETS];

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_victim;
    logic                 w_victim_nxt;

    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [LINE_W-1:0]    r_mem_wdata;
    logic                 w_mem_req_nxt;
    logic                 w_mem_we_nxt;
    logic [ADDRESS_WIDTH-1:0] w_mem_addr_nxt;
    logic [LINE_W-1:0]    w_mem_wdata_nxt;

    logic                 w_cpu_ready;
    logic [DATA_WIDTH-1:0] w_cpu_rdata;

    // ------------------------------------------------------------------
    // Address decode and lookup
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]     w_off;
    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_unused_byte;   // byte lanes are not used: whole-word access only

    assign w_off         = cpu_addr[LSB_W-1:2];
    assign w_idx         = cpu_addr[LSB_W +: IDX_W];
    assign w_tag         = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_unused_byte = cpu_addr[1:0];

    logic w_hit0, w_hit1, w_hit, w_hit_way;
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = w_hit1;

    logic [LINE_W-1:0] w_hit_line;
    logic [LINE_W-1:0] w_done_line;
    assign w_hit_line  = w_hit_way ? r_data[1][w_idx] : r_data[0][w_idx];
    assign w_done_line = r_victim  ? r_data[1][w_idx] : r_data[0][w_idx];

    // Victim: an invalid way first (way 0 preferred), otherwise the LRU way.
    logic w_victim_sel;
    always_comb begin
        w_victim_sel = r_lru[w_idx];
        if (!r_valid[0][w_idx]) begin
            w_victim_sel = 1'b0;
        end else if (!r_valid[1][w_idx]) begin
            w_victim_sel = 1'b1;
        end
    end

    logic w_victim_dirty;
    assign w_victim_dirty = r_valid[w_victim_sel][w_idx] && r_dirty[w_victim_sel][w_idx];

    // Event strobes shared by the state, status and data updates.
    logic w_idle_hit, w_idle_miss, w_wb_ack, w_refill_ack, w_done;
    assign w_idle_hit   = (r_state == IDLE) && cpu_req && w_hit;
    assign w_idle_miss  = (r_state == IDLE) && cpu_req && !w_hit;
    assign w_wb_ack     = (r_state == WRITEBACK) && mem_ack;
    assign w_refill_ack = (r_state == REFILL) && mem_ack;
    assign w_done       = (r_state == DONE);

    logic w_word_wr, w_wr_way;
    assign w_word_wr = cpu_we && (w_idle_hit || w_done);
    assign w_wr_way  = w_done ? r_victim : w_hit_way;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_victim    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_victim    <= w_victim_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs. Memory-side outputs are registered so
    // they stay put while waiting for mem_ack; only the CPU side is
    // combinational, which is what gives the zero-wait hit.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_victim_nxt    = r_victim;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_ready     = 1'b0;
        w_cpu_rdata     = '0;

        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    if (w_hit) begin
                        w_cpu_ready = 1'b1;
                        w_cpu_rdata = w_hit_line[w_off*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        w_victim_nxt  = w_victim_sel;
                        w_mem_req_nxt = 1'b1;
                        if (w_victim_dirty) begin
                            w_state_nxt     = WRITEBACK;
                            w_mem_we_nxt    = 1'b1;
                            w_mem_addr_nxt  = {r_tag[w_victim_sel][w_idx], w_idx, {LSB_W{1'b0}}};
                            w_mem_wdata_nxt = r_data[w_victim_sel][w_idx];
                        end else begin
                            w_state_nxt     = REFILL;
                            w_mem_we_nxt    = 1'b0;
                            w_mem_addr_nxt  = {w_tag, w_idx, {LSB_W{1'b0}}};
                            w_mem_wdata_nxt = '0;
                        end
                    end
                end
            end

            WRITEBACK: begin
                // mem_req stays high straight into the refill.
                if (mem_ack) begin
                    w_state_nxt     = REFILL;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = {w_tag, w_idx, {LSB_W{1'b0}}};
                    w_mem_wdata_nxt = '0;
                end
            end

            REFILL: begin
                if (mem_ack) begin
                    w_state_nxt     = DONE;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = '0;
                end
            end

            DONE: begin
                // Installed line is already in the array; a store merges at this edge.
                w_cpu_ready = 1'b1;
                w_cpu_rdata = w_done_line[w_off*DATA_WIDTH +: DATA_WIDTH];
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gated by rst_n so the CPU never sees a completion while reset is held.
    assign cpu_ready = w_cpu_ready && rst_n;
    assign cpu_rdata = rst_n ? w_cpu_rdata : '0;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Status bits: valid, dirty, LRU
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_lru   <= '0;
        end else begin
            if (w_idle_hit) begin
                r_lru[w_idx] <= ~w_hit_way;
                if (cpu_we) begin
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
                end
            end
            if (w_wb_ack) begin
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
            if (w_refill_ack) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
            if (w_done) begin
                r_lru[w_idx] <= ~r_victim;
                if (cpu_we) begin
                    r_dirty[r_victim][w_idx] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (no reset). Refill and store never coincide:
    // the store into a refilled line happens one cycle later, in DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_refill_ack) begin
            r_data[r_victim][w_idx] <= mem_rdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
        if (w_word_wr) begin
            r_data[w_wr_way][w_idx][w_off*DATA_WIDTH +: DATA_WIDTH] <= cpu_wdata;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    // ------------------------------------------------------------------
    // Hit/miss counters, free-running with natural 32-bit wrap.
    // ------------------------------------------------------------------
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_idle_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_idle_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused_miss;
    assign w_unused_miss = w_idle_miss;
`endif

endmodule
